// File: rtl/simple_adder.sv
// Unsigned W-bit adder with a combinational sum, a registered sum/carry stage and a sticky overflow flag.
// Define SIMPLE_ADDER_SAT_EN to clamp the sum to all-ones when the add carries out.
module simple_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x_0,
  input  logic [W-1:0] x_1,
  input  logic         in_valid,
  input  logic         clr_ovf,
  output logic [W-1:0] result,
  output logic         carry,
  output logic [W-1:0] result_q,
  output logic         carry_q,
  output logic         out_valid,
  output logic         ovf_sticky
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_wrap;
  logic         w_carry;
  logic [W-1:0] w_result;

  logic [W-1:0] r_result_q;
  logic         r_carry_q;
  logic         r_out_valid;
  logic         r_ovf_sticky;

  // Widen by one bit so the carry-out falls out of the same addition.
  assign w_sum   = {1'b0, x_0} + {1'b0, x_1};
  assign w_wrap  = w_sum[W-1:0];
  assign w_carry = w_sum[W];

`ifdef SIMPLE_ADDER_SAT_EN
  assign w_result = w_carry ? {W{1'b1}} : w_wrap;
`else
  assign w_result = w_wrap;
`endif

  assign result = w_result;
  assign carry  = w_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_q  <= '0;
      r_carry_q   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result_q <= w_result;
        r_carry_q  <= w_carry;
      end
    end
  end

  // A carrying valid add outranks a simultaneous clear so no overflow is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (in_valid && w_carry) begin
      r_ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign result_q   = r_result_q;
  assign carry_q    = r_carry_q;
  assign out_valid  = r_out_valid;
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_simple_adder.sv
// Self-checking bench for simple_adder (W=8) against an arithmetic reference model.
// Honours SIMPLE_ADDER_SAT_EN when computing expected sums.
module tb_simple_adder;

  logic       clk;
  logic       rst;
  logic [7:0] x_0;
  logic [7:0] x_1;
  logic       in_valid;
  logic       clr_ovf;
  logic [7:0] result;
  logic       carry;
  logic [7:0] result_q;
  logic       carry_q;
  logic       out_valid;
  logic       ovf_sticky;

  int errors = 0;
  int checks = 0;

  simple_adder #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .x_0        (x_0),
    .x_1        (x_1),
    .in_valid   (in_valid),
    .clr_ovf    (clr_ovf),
    .result     (result),
    .carry      (carry),
    .result_q   (result_q),
    .carry_q    (carry_q),
    .out_valid  (out_valid),
    .ovf_sticky (ovf_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference sum from plain integer arithmetic.
  function automatic logic [7:0] exp_sum(input int a, input int b);
    int s;
    s = a + b;
`ifdef SIMPLE_ADDER_SAT_EN
    if (s > 255) return 8'hFF;
`endif
    return 8'(s % 256);
  endfunction

  function automatic logic exp_carry(input int a, input int b);
    return (a + b) > 255;
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v, input logic c);
    @(negedge clk);
    x_0 = a; x_1 = b; in_valid = v; clr_ovf = c;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x_0 = 8'h00; x_1 = 8'h00; in_valid = 1'b1; clr_ovf = 1'b0;
    step();
    checks++; if (result_q !== 8'h00) begin errors++; $display("FAIL reset_result_q got=%h exp=00", result_q); end
    checks++; if (carry_q !== 1'b0) begin errors++; $display("FAIL reset_carry_q got=%b exp=0", carry_q); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
    checks++; if (result !== 8'h00 || carry !== 1'b0) begin errors++; $display("FAIL reset_zero_add got=%b/%h exp=0/00", carry, result); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_comb();
    @(negedge clk);
    #2;
    x_0 = 8'h24; x_1 = 8'h81;
    #1;
    checks++; if (result !== 8'hA5) begin errors++; $display("FAIL comb_a5_result got=%h exp=a5", result); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL comb_a5_carry got=%b exp=0", carry); end
  endtask

  task automatic test_registered();
    drive(8'h09, 8'h63, 1'b1, 1'b0);
    checks++; if (result !== 8'h6C || carry !== 1'b0) begin errors++; $display("FAIL reg_comb got=%b/%h exp=0/6c", carry, result); end
    step();
    checks++; if (result_q !== 8'h6C) begin errors++; $display("FAIL reg_result_q got=%h exp=6c", result_q); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reg_out_valid got=%b exp=1", out_valid); end
    checks++; if (carry_q !== 1'b0) begin errors++; $display("FAIL reg_carry_q got=%b exp=0", carry_q); end
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reg_out_valid_drop got=%b exp=0", out_valid); end
    checks++; if (result_q !== 8'h6C) begin errors++; $display("FAIL reg_hold got=%h exp=6c", result_q); end
  endtask

  task automatic test_overflow();
    // A carrying add with in_valid low must not set the flag.
    drive(8'hFF, 8'hFF, 1'b0, 1'b0);
    step();
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_invalid_add got=%b exp=0", ovf_sticky); end
    drive(8'hFF, 8'h01, 1'b1, 1'b0);
    checks++; if (result !== exp_sum(255, 1)) begin errors++; $display("FAIL ovf_result got=%h exp=%h", result, exp_sum(255, 1)); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL ovf_carry got=%b exp=1", carry); end
    step();
    checks++; if (carry_q !== 1'b1) begin errors++; $display("FAIL ovf_carry_q got=%b exp=1", carry_q); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_sticky); end
    checks++; if (result_q !== exp_sum(255, 1)) begin errors++; $display("FAIL ovf_result_q got=%h exp=%h", result_q, exp_sum(255, 1)); end
  endtask

  task automatic test_clear();
    drive(8'h01, 8'h02, 1'b1, 1'b1);
    step();
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL clr_clears got=%b exp=0", ovf_sticky); end
    drive(8'h80, 8'h80, 1'b1, 1'b0);
    step();
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL clr_reset got=%b exp=1", ovf_sticky); end
    drive(8'hC0, 8'h41, 1'b1, 1'b1);
    step();
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL clr_set_wins got=%b exp=1", ovf_sticky); end
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL clr_hold got=%b exp=1", ovf_sticky); end
  endtask

  task automatic test_reset_midstream();
    drive(8'hFF, 8'hFF, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    checks++; if (result_q !== 8'h00 || carry_q !== 1'b0) begin errors++; $display("FAIL mid_rst_regs got=%b/%h exp=0/00", carry_q, result_q); end
    checks++; if (out_valid !== 1'b0 || ovf_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got=%b/%b exp=0/0", out_valid, ovf_sticky); end
    x_0 = 8'h30; x_1 = 8'h05;
    #1;
    checks++; if (result !== 8'h35 || carry !== 1'b0) begin errors++; $display("FAIL mid_rst_comb got=%b/%h exp=0/35", carry, result); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_random_comb();
    int a, b;
    in_valid = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      x_0 = 8'(a); x_1 = 8'(b);
      #5;
      checks++;
      if (result !== exp_sum(a, b) || carry !== exp_carry(a, b)) begin
        errors++;
        $display("FAIL rand_comb[%0d] %h+%h got=%b/%h exp=%b/%h", i, a, b, carry, result, exp_carry(a, b), exp_sum(a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, b;
    logic v, c;
    logic [7:0] m_rq = result_q;
    logic m_cq = carry_q;
    logic m_ovf = ovf_sticky;
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      v = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 3) == 0);
      drive(8'(a), 8'(b), v, c);
      if (v) begin
        m_rq = exp_sum(a, b);
        m_cq = exp_carry(a, b);
      end
      if (v && exp_carry(a, b)) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      step();
      checks++;
      if (result_q !== m_rq || carry_q !== m_cq || out_valid !== v || ovf_sticky !== m_ovf) begin
        errors++;
        $display("FAIL b2b[%0d] got rq=%h cq=%b ov=%b ovf=%b exp rq=%h cq=%b ov=%b ovf=%b",
                 i, result_q, carry_q, out_valid, ovf_sticky, m_rq, m_cq, v, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_registered();
    test_overflow();
    test_clear();
    test_reset_midstream();
    test_random_comb();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
